alu_bist_ctrl: RTL and testbench

//  - Hardware ALU stimulus source and result checker: the driving end of the ALU operand/result interface.
//  - Generates scrA/scrB/AluControl, samples ALUresult/Flag and folds them into a 32-bit MISR signature.
//  - Compares the final signature with a golden value: power-on/self-test of the RV32 ALU, no bench needed.

---
 rtl/alu_bist_ctrl_pkg.sv | 28 ++
 rtl/alu_bist_ctrl_if.sv | 13 +
 rtl/alu_bist_ctrl_lfsr32.sv | 26 ++
 rtl/alu_bist_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_bist_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_bist_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the ALU built-in self-test controller.
package alu_bist_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StDone} state_e;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] SCRB_MASK   = 32'hA5A5_A5A5;
  localparam int unsigned NUM_CORNERS = 4;

  // Corner operand pairs, returned as {A, B}.
  function automatic logic [63:0] corner_pair(input logic [1:0] idx);
    logic [63:0] pair;
    unique case (idx)
      2'd0:    pair = {32'h0000_0000, 32'h0000_0000};
      2'd1:    pair = {32'hFFFF_FFFF, 32'h0000_0001};
      2'd2:    pair = {32'h8000_0000, 32'hFFFF_FFFF};
      default: pair = {32'h7FFF_FFFF, 32'h0000_0001};
    endcase
    return pair;
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] res,
                                            input logic [2:0] flag);
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ res ^ {29'b0, flag};
  endfunction

endpackage

// File: rtl/alu_bist_ctrl_if.sv
// ALU operand/result bus: master drives operands and op code, slave (the ALU) returns result/flags.
interface alu_bist_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] scrA;
  logic [WIDTH-1:0] scrB;
  logic [2:0]       AluControl;
  logic [WIDTH-1:0] ALUresult;
  logic [2:0]       Flag;

  modport master (output scrA, scrB, AluControl, input ALUresult, Flag);
  modport slave (input scrA, scrB, AluControl, output ALUresult, Flag);
endinterface

// File: rtl/alu_bist_ctrl_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load of the seed and step enable.
module alu_bist_ctrl_lfsr32
  import alu_bist_ctrl_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= {1'b0, r_state[31:1]} ^ (r_state[0] ? LFSR_TAPS : 32'h0);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU self-test: sweeps ops x LFSR vectors, folds result/flags into a MISR, compares to golden.
// ALU_BIST_CORNER_EN adds four fixed operand pairs ahead of each op's random vectors.
module alu_bist_ctrl
  import alu_bist_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned OPS        = 8,
  parameter int unsigned VECTORS    = 256,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [31:0]            signature,
  alu_bist_ctrl_if.master        alu
);

`ifdef ALU_BIST_CORNER_EN
  localparam int unsigned PER_OP = VECTORS + NUM_CORNERS;
`else
  localparam int unsigned PER_OP = VECTORS;
`endif
  localparam int unsigned VW = $clog2(PER_OP + 1);
  localparam int unsigned OW = $clog2(OPS + 1);

  state_e           r_state;
  logic [VW-1:0]    r_vec;
  logic [OW-1:0]    r_op;
  logic [WIDTH-1:0] r_scra, r_scrb;
  logic [2:0]       r_ctl;
  logic [31:0]      r_sig;
  logic             r_busy, r_done, r_pass;
  logic [31:0]      w_lfsr;
  logic             w_accept, w_corner, w_last_vec;
  logic [63:0]      w_pair;

  // Start is only taken while idle or after done has been published (busy already low).
  assign w_accept   = start && !r_busy && (r_state == StIdle || r_state == StDone);
  assign w_last_vec = (r_vec == VW'(PER_OP - 1));

`ifdef ALU_BIST_CORNER_EN
  assign w_corner = (r_vec < VW'(NUM_CORNERS));
  assign w_pair   = corner_pair(r_vec[1:0]);
`else
  assign w_corner = 1'b0;
  assign w_pair   = 64'h0;
`endif

  alu_bist_ctrl_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_step  ((r_state == StDrive) && !w_corner),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_vec   <= '0;
      r_op    <= '0;
      r_scra  <= '0;
      r_scrb  <= '0;
      r_ctl   <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            r_state <= StDrive;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_sig   <= '0;
            r_vec   <= '0;
            r_op    <= '0;
          end else if (r_state == StDone && r_busy) begin
            // First cycle in StDone publishes the verdict.
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (r_sig == GOLDEN_SIG);
          end
        end
        StDrive: begin
          r_scra  <= w_corner ? WIDTH'(w_pair[63:32]) : WIDTH'(w_lfsr);
          r_scrb  <= w_corner ? WIDTH'(w_pair[31:0])
                              : WIDTH'({w_lfsr[18:0], w_lfsr[31:19]} ^ SCRB_MASK);
          r_ctl   <= 3'(r_op);
          r_state <= StCapture;
        end
        StCapture: begin
          r_sig <= misr_next(r_sig, 32'(alu.ALUresult), alu.Flag);
          if (w_last_vec) begin
            r_vec <= '0;
            if (r_op == OW'(OPS - 1)) begin
              r_state <= StDone;
            end else begin
              r_op    <= r_op + OW'(1);
              r_state <= StDrive;
            end
          end else begin
            r_vec   <= r_vec + VW'(1);
            r_state <= StDrive;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign alu.scrA       = r_scra;
  assign alu.scrB       = r_scrb;
  assign alu.AluControl = r_ctl;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign signature      = r_sig;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: four instances paired with a reference ALU, scoreboarded vectors/signatures.
module tb_alu_bist_ctrl;

`ifdef ALU_BIST_CORNER_EN
  localparam bit CX = 1'b1;
`else
  localparam bit CX = 1'b0;
`endif

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = {31'b0, $signed(a) < $signed(b)};
      3'd6:    r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return {r == 32'h0, r[31], a < b, r};
  endfunction

  function automatic logic [63:0] corner_ab(input int v);
    logic [63:0] p;
    case (v)
      0:       p = {32'h0000_0000, 32'h0000_0000};
      1:       p = {32'hFFFF_FFFF, 32'h0000_0001};
      2:       p = {32'h8000_0000, 32'hFFFF_FFFF};
      default: p = {32'h7FFF_FFFF, 32'h0000_0001};
    endcase
    return p;
  endfunction

  function automatic logic [31:0] model_sig(input int ops, input int vecs, input bit corner);
    logic [31:0] l, s, a, b;
    logic [34:0] r;
    logic [63:0] p;
    int per;
    l = 32'h1;
    s = 32'h0;
    per = vecs + (corner ? 4 : 0);
    for (int o = 0; o < ops; o++) begin
      for (int v = 0; v < per; v++) begin
        if (corner && v < 4) begin
          p = corner_ab(v);
          a = p[63:32];
          b = p[31:0];
        end else begin
          a = l;
          b = {l[18:0], l[31:19]} ^ 32'hA5A5_A5A5;
          l = lfsr_step(l);
        end
        r = alu_model(a, b, o[2:0]);
        s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ r[31:0] ^ {29'b0, r[34:32]};
      end
    end
    return s;
  endfunction

  localparam logic [31:0] GOLD_P = model_sig(2, 4, CX);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_v, start_v, busy_v, done_v, pass_v;
  logic [66:0] vec_v [4];
  logic [31:0] sig_v [4];
  int checks = 0;
  int failures = 0;
  logic [66:0] q_vec [$];
  logic [31:0] q_sig [$];

  alu_bist_ctrl_if u_if0 ();
  alu_bist_ctrl_if u_if1 ();
  alu_bist_ctrl_if u_if2 ();
  alu_bist_ctrl_if u_if3 ();

  assign {u_if0.Flag, u_if0.ALUresult} = alu_model(u_if0.scrA, u_if0.scrB, u_if0.AluControl);
  assign {u_if1.Flag, u_if1.ALUresult} = alu_model(u_if1.scrA, u_if1.scrB, u_if1.AluControl);
  assign {u_if2.Flag, u_if2.ALUresult} = alu_model(u_if2.scrA, u_if2.scrB, u_if2.AluControl);
  assign {u_if3.Flag, u_if3.ALUresult} = alu_model(u_if3.scrA, u_if3.scrB, u_if3.AluControl);
  assign vec_v[0] = {u_if0.scrA, u_if0.scrB, u_if0.AluControl};
  assign vec_v[1] = {u_if1.scrA, u_if1.scrB, u_if1.AluControl};
  assign vec_v[2] = {u_if2.scrA, u_if2.scrB, u_if2.AluControl};
  assign vec_v[3] = {u_if3.scrA, u_if3.scrB, u_if3.AluControl};

  alu_bist_ctrl #(.OPS(1), .VECTORS(1)) u_s (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .signature(sig_v[0]), .alu(u_if0)
  );
  alu_bist_ctrl u_f (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .signature(sig_v[1]), .alu(u_if1)
  );
  alu_bist_ctrl #(.OPS(2), .VECTORS(4), .GOLDEN_SIG(GOLD_P)) u_p (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .signature(sig_v[2]), .alu(u_if2)
  );
  alu_bist_ctrl #(.OPS(2), .VECTORS(4), .GOLDEN_SIG(GOLD_P ^ 32'h1)) u_n (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .pass(pass_v[3]), .signature(sig_v[3]), .alu(u_if3)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int d, input string tag);
    check(tag, {vec_v[d], sig_v[d], busy_v[d], done_v[d], pass_v[d]}, 128'h0);
  endtask

  task automatic push_run(input int ops, input int vecs);
    logic [31:0] l;
    logic [63:0] p;
    int per;
    l = 32'h1;
    per = vecs + (CX ? 4 : 0);
    for (int o = 0; o < ops; o++) begin
      for (int v = 0; v < per; v++) begin
        if (CX && v < 4) begin
          p = corner_ab(v);
          q_vec.push_back({p, o[2:0]});
        end else begin
          q_vec.push_back({l, {l[18:0], l[31:19]} ^ 32'hA5A5_A5A5, o[2:0]});
          l = lfsr_step(l);
        end
      end
    end
    q_sig.push_back(model_sig(ops, vecs, CX));
  endtask

  // One full run on instance d; poke_at >= 0 re-asserts start mid-run for one cycle.
  task automatic run(input int d, input int ops, input int vecs, input logic [31:0] gold,
                     input int poke_at);
    int n;
    int total;
    logic [31:0] es;
    total = ops * (vecs + (CX ? 4 : 0));
    q_vec.delete();
    q_sig.delete();
    push_run(ops, vecs);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    check("busy_after_start", {busy_v[d], done_v[d]}, 128'b10);
    n = 0;
    while (done_v[d] !== 1'b1 && n < 2 * total + 20) begin
      start_v[d] = (n == poke_at);
      tick();
      n++;
      if (n % 2 == 1 && q_vec.size() > 0) check("vector", vec_v[d], q_vec.pop_front());
    end
    start_v[d] = 1'b0;
    check("done_latency", n, 2 * total + 1);
    check("vectors_consumed", q_vec.size(), 0);
    es = q_sig.pop_front();
    check("signature", sig_v[d], es);
    check("pass", pass_v[d], es == gold);
    check("busy_low", busy_v[d], 1'b0);
    tick();
    check("done_held", {done_v[d], busy_v[d], sig_v[d]}, {2'b10, es});
  endtask

  initial begin
    int n;
    rst_v   = 4'hF;
    start_v = 4'h0;
    tick();
    tick();
    for (int d = 0; d < 4; d++) check_zero(d, "reset_state");
    rst_v = 4'h0;

    run(0, 1, 1, 32'h0, -1);

    // start held high: restart right after done is seen, one run per acceptance
    start_v[0] = 1'b1;
    tick();
    check("hold_restart", {busy_v[0], done_v[0], sig_v[0]}, {2'b10, 32'h0});
    n = 0;
    while (done_v[0] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("hold_latency", n, 2 * (1 + (CX ? 4 : 0)) + 1);
    start_v[0] = 1'b0;

    run(1, 8, 256, 32'h0, -1);
    run(1, 8, 256, 32'h0, 10);

    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (99) tick();
    rst_v[1] = 1'b1;
    tick();
    check_zero(1, "rst_midrun");
    rst_v[1] = 1'b0;
    tick();
    check_zero(1, "rst_idle");
    run(1, 8, 256, 32'h0, -1);

    run(2, 2, 4, GOLD_P, -1);
    run(3, 2, 4, GOLD_P ^ 32'h1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
